// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//    Shares one single-port, synchronous-read data memory between two masters.
//    Port 0 is the CPU data path and port 1 is a DMA/IO master. The arbiter
//    grants at most one access per cycle and drives the memory enable, byte
//    write enables, address and write data from the granted port. The memory
//    has a 1-cycle read latency, so each read's data is returned to the port
//    that issued it one cycle after that read was granted.
//
// Configuration macro:
//    DMEM_ARB_RR_EN  - when defined, a round-robin arbiter replaces the
//                      fixed-priority arbiter and its starvation counter.
//                      MAX_WAIT is then ignored. When undefined (the default),
//                      port 0 has priority and port 1 is forced through after
//                      MAX_WAIT consecutive denied cycles.
//
// Ports:
//    clk        in   clock, all state updates on the rising edge
//    rst        in   synchronous active-high reset
//    pN_req     in   port N access request, held until pN_gnt
//    pN_we      in   port N byte write enables, all zero means read
//    pN_addr    in   port N word address
//    pN_wdata   in   port N write data
//    pN_gnt     out  port N request accepted this cycle (combinational)
//    pN_rvalid  out  port N read data valid (registered)
//    pN_rdata   out  port N read data (memory output, qualified by rvalid)
//    mem_en     out  memory enable
//    mem_we     out  memory byte write enables
//    mem_addr   out  memory word address
//    mem_din    out  memory write data
//    mem_dout   in   memory read data, valid the cycle after a read is issued
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AWIDTH   = 14,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req,
    input  logic [DWIDTH/8-1:0]   p0_we,
    input  logic [AWIDTH-1:0]     p0_addr,
    input  logic [DWIDTH-1:0]     p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DWIDTH-1:0]     p0_rdata,

    input  logic                  p1_req,
    input  logic [DWIDTH/8-1:0]   p1_we,
    input  logic [AWIDTH-1:0]     p1_addr,
    input  logic [DWIDTH-1:0]     p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DWIDTH-1:0]     p1_rdata,

    output logic                  mem_en,
    output logic [DWIDTH/8-1:0]   mem_we,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_din,
    input  logic [DWIDTH-1:0]     mem_dout
);

    localparam int BW = DWIDTH / 8;

    // One-hot record of which port issued the read now being returned.
    logic [1:0] rd_owner_q;
    logic [1:0] rd_owner_d;

    // Decides who wins when both ports request in the same cycle.
    logic p1Wins;

`ifdef DMEM_ARB_RR_EN
    // Round-robin: remember the last granted port, favour the other one.
    // Reset value of 1 means port 0 wins the first conflict after reset.
    logic last_gnt_q;
    logic last_gnt_d;

    assign p1Wins = (last_gnt_q == 1'b0);

    // The last-grant pointer only moves when a grant is actually issued.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (p0_gnt) begin
            last_gnt_d = 1'b0;
        end else if (p1_gnt) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    // Fixed priority with a starvation guard: port 0 normally wins, but once
    // port 1 has been denied MAX_WAIT cycles in a row it is let through.
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    assign p1Wins = (wait_cnt_q == MAX_CNT);

    // Count consecutive denied cycles of port 1, saturating at MAX_WAIT.
    // Any grant to port 1, or port 1 dropping its request, restarts the count.
    always_comb begin
        wait_cnt_d = '0;
        if (p1_req && !p1_gnt) begin
            if (wait_cnt_q == MAX_CNT) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // Grant logic. Nothing is granted while reset is held, so the memory is
    // never touched during reset. A lone requester is granted immediately.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p0_req && p1_req) begin
                if (p1Wins) begin
                    p1_gnt = 1'b1;
                end else begin
                    p0_gnt = 1'b1;
                end
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    // Memory command mux. Address and data simply follow port 0 when idle;
    // only the enable and write enables must be forced low.
    always_comb begin
        mem_en   = p0_gnt | p1_gnt;
        mem_we   = '0;
        mem_addr = p0_addr;
        mem_din  = p0_wdata;
        if (p1_gnt) begin
            mem_we   = p1_we;
            mem_addr = p1_addr;
            mem_din  = p1_wdata;
        end else if (p0_gnt) begin
            mem_we   = p0_we;
        end
    end

    // A granted read (no byte enables set) marks its port as the owner of
    // next cycle's memory output; writes and idle cycles mark nobody.
    always_comb begin
        rd_owner_d    = 2'b00;
        rd_owner_d[0] = p0_gnt && (p0_we == {BW{1'b0}});
        rd_owner_d[1] = p1_gnt && (p1_we == {BW{1'b0}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_q <= 2'b00;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Gating with rst drops the return of a read that was granted just
    // before reset, so the requester sees no stale rvalid and must reissue.
    assign p0_rvalid = rd_owner_q[0] & ~rst;
    assign p1_rvalid = rd_owner_q[1] & ~rst;

    // Both ports see the raw memory output; rvalid tells each whether it's theirs.
    assign p0_rdata = mem_dout;
    assign p1_rdata = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed testbench for dmem_arbiter. A small behavioural memory with
// byte write enables and 1-cycle read latency sits on the memory side.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AWIDTH = 14;
    localparam int DWIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p1_req;
    logic [3:0]        p0_we, p1_we;
    logic [AWIDTH-1:0] p0_addr, p1_addr;
    logic [DWIDTH-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DWIDTH-1:0] p0_rdata, p1_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [DWIDTH-1:0] mem_dout = '0;

    int testCount = 0;
    int failCount = 0;
    logic loadMem = 1'b1;
    logic [31:0] memArr [0:255];

    dmem_arbiter #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Merge write data into an existing word under byte enables.
    function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                               input logic [31:0] din,
                                               input logic [3:0]  we);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) w[8*b +: 8] = din[8*b +: 8];
        end
        return w;
    endfunction

    // Behavioural single-port memory: preloaded on the first edge, then
    // byte-enabled writes and registered reads.
    always @(posedge clk) begin
        if (loadMem) begin
            memArr[8'h01] <= 32'hA1A1A1A1;
            memArr[8'h02] <= 32'hB2B2B2B2;
            memArr[8'h03] <= 32'h11223344;
            memArr[8'h10] <= 32'hDEADBEEF;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_dout <= memArr[mem_addr[7:0]];
            end else begin
                memArr[mem_addr[7:0]] <= mergeBytes(memArr[mem_addr[7:0]], mem_din, mem_we);
            end
        end
    end

    // Drive one port's request fields.
    task automatic applyStimulus(input int port, input logic req, input logic [3:0] we,
                                 input logic [AWIDTH-1:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Hold reset for two cycles with both ports idle.
    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        applyStimulus(1, 1'b0, 4'h0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Both ports request continuously: check grant order and read returns.
    task automatic runBothReq(input int n);
        logic prevP0, prevP1, expP1;
        prevP0 = 1'b0;
        prevP1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            applyStimulus(0, 1'b1, 4'h0, 14'h0001, '0);
            applyStimulus(1, 1'b1, 4'h0, 14'h0002, '0);
            #1;
`ifdef DMEM_ARB_RR_EN
            expP1 = (i % 2) == 1;
`else
            expP1 = (i % 5) == 4;
`endif
            checkOutput($sformatf("both_p0_gnt_%0d", i), {31'b0, p0_gnt}, {31'b0, !expP1});
            checkOutput($sformatf("both_p1_gnt_%0d", i), {31'b0, p1_gnt}, {31'b0, expP1});
            checkOutput($sformatf("both_p0_rvalid_%0d", i), {31'b0, p0_rvalid}, {31'b0, prevP0});
            checkOutput($sformatf("both_p1_rvalid_%0d", i), {31'b0, p1_rvalid}, {31'b0, prevP1});
            if (prevP0) checkOutput($sformatf("both_p0_rdata_%0d", i), p0_rdata, 32'hA1A1A1A1);
            if (prevP1) checkOutput($sformatf("both_p1_rdata_%0d", i), p1_rdata, 32'hB2B2B2B2);
            prevP0 = !expP1;
            prevP1 = expP1;
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        applyStimulus(1, 1'b0, 4'h0, '0, '0);
        #1;
        checkOutput("both_last_p0_rvalid", {31'b0, p0_rvalid}, {31'b0, prevP0});
        checkOutput("both_last_p1_rvalid", {31'b0, p1_rvalid}, {31'b0, prevP1});
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        applyStimulus(1, 1'b0, 4'h0, '0, '0);

        // Reset: requests are ignored while rst is high.
        @(negedge clk);
        loadMem = 1'b0;
        applyStimulus(0, 1'b1, 4'h0, 14'h0010, '0);
        applyStimulus(1, 1'b1, 4'h0, 14'h0002, '0);
        #1;
        checkOutput("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
        checkOutput("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        checkOutput("rst_mem_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        applyStimulus(1, 1'b0, 4'h0, '0, '0);
        #1;
        checkOutput("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        checkOutput("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        checkOutput("idle_mem_en", {31'b0, mem_en}, 32'd0);

        // Test 1: single p0 read.
        @(negedge clk);
        applyStimulus(0, 1'b1, 4'h0, 14'h0010, '0);
        #1;
        checkOutput("t1_p0_gnt", {31'b0, p0_gnt}, 32'd1);
        checkOutput("t1_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        checkOutput("t1_mem_en", {31'b0, mem_en}, 32'd1);
        checkOutput("t1_mem_addr", {18'b0, mem_addr}, 32'h10);
        checkOutput("t1_mem_we", {28'b0, mem_we}, 32'd0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        #1;
        checkOutput("t1_p0_rvalid", {31'b0, p0_rvalid}, 32'd1);
        checkOutput("t1_p0_rdata", p0_rdata, 32'hDEADBEEF);
        checkOutput("t1_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t1_p0_rvalid_drop", {31'b0, p0_rvalid}, 32'd0);

        // Test 2: p1 byte write to lane 2, then read back.
        @(negedge clk);
        applyStimulus(1, 1'b1, 4'b0100, 14'h0003, 32'h00AB0000);
        #1;
        checkOutput("t2_p1_gnt_wr", {31'b0, p1_gnt}, 32'd1);
        checkOutput("t2_mem_we", {28'b0, mem_we}, 32'h4);
        checkOutput("t2_mem_din", mem_din, 32'h00AB0000);
        @(negedge clk);
        applyStimulus(1, 1'b1, 4'b0000, 14'h0003, '0);
        #1;
        checkOutput("t2_p1_rvalid_wr", {31'b0, p1_rvalid}, 32'd0);
        checkOutput("t2_p1_gnt_rd", {31'b0, p1_gnt}, 32'd1);
        @(negedge clk);
        applyStimulus(1, 1'b0, 4'h0, '0, '0);
        #1;
        checkOutput("t2_p1_rvalid_rd", {31'b0, p1_rvalid}, 32'd1);
        checkOutput("t2_p1_rdata", p1_rdata, 32'h11AB3344);
        checkOutput("t2_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);

        // Test 3 / 4: continuous contention.
`ifdef DMEM_ARB_RR_EN
        resetDut();
        runBothReq(8);
`else
        runBothReq(12);
`endif

        // Test 5: reset right after a granted read.
        @(negedge clk);
        applyStimulus(0, 1'b1, 4'h0, 14'h0010, '0);
        #1;
        checkOutput("t5_p0_gnt", {31'b0, p0_gnt}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 1'b1, 4'h0, 14'h0002, '0);
        #1;
        checkOutput("t5_rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        checkOutput("t5_rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
        checkOutput("t5_rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        checkOutput("t5_rst_mem_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        applyStimulus(1, 1'b0, 4'h0, '0, '0);
        #1;
        checkOutput("t5_post_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 4'h0, 14'h0010, '0);
        #1;
        checkOutput("t5_reissue_gnt", {31'b0, p0_gnt}, 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        #1;
        checkOutput("t5_reissue_rvalid", {31'b0, p0_rvalid}, 32'd1);
        checkOutput("t5_reissue_rdata", p0_rdata, 32'hDEADBEEF);

        // Test 6: alternating single-port reads every cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(0, (i % 2) == 0, 4'h0, 14'h0001, '0);
            applyStimulus(1, (i % 2) == 1, 4'h0, 14'h0002, '0);
            #1;
            checkOutput($sformatf("t6_mem_en_%0d", i), {31'b0, mem_en}, 32'd1);
            checkOutput($sformatf("t6_p0_gnt_%0d", i), {31'b0, p0_gnt}, {31'b0, (i % 2) == 0});
            checkOutput($sformatf("t6_p1_gnt_%0d", i), {31'b0, p1_gnt}, {31'b0, (i % 2) == 1});
            if (i > 0) begin
                checkOutput($sformatf("t6_p0_rvalid_%0d", i), {31'b0, p0_rvalid}, {31'b0, (i % 2) == 1});
                checkOutput($sformatf("t6_p1_rvalid_%0d", i), {31'b0, p1_rvalid}, {31'b0, (i % 2) == 0});
                checkOutput($sformatf("t6_rdata_%0d", i), mem_dout,
                            ((i % 2) == 1) ? 32'hA1A1A1A1 : 32'hB2B2B2B2);
            end
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, 4'h0, '0, '0);
        applyStimulus(1, 1'b0, 4'h0, '0, '0);
        #1;
        checkOutput("t6_last_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
        checkOutput("t6_last_p1_rdata", p1_rdata, 32'hB2B2B2B2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
